// File: rtl/axi4_lite_ctrl_regs.sv
// AXI4-Lite control/status register slave for the MLDSA core (CTRL, STATUS, CFG[i]).
// Defining MLDSA_CTRL_IRQ_EN adds the irq output and CTRL.IRQ_ENABLE (bit1).
module axi4_lite_ctrl_regs #(
  parameter int ADDR_W  = 12,
  parameter int MODE_W  = 2,
  parameter int NUM_CFG = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR_W-1:0]     AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [31:0]           WDATA,
  input  logic [3:0]            WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_W-1:0]     ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [31:0]           RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [MODE_W-1:0]     main_mode,
  output logic [32*NUM_CFG-1:0] cfg_flat,
  output logic                  start_pulse,
`ifdef MLDSA_CTRL_IRQ_EN
  output logic                  irq,
`endif
  input  logic                  done,
  output logic                  busy
);
  localparam int WA_W = ADDR_W - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic            aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [WA_W-1:0] awaddr_q, awaddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic            bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]      bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [31:0]     cfg_q [NUM_CFG];
  logic [31:0]     cfg_d [NUM_CFG];
  logic            busy_q, busy_d, start_q, start_d;
  logic            done_st_q, done_st_d, start_err_q, start_err_d;
`ifdef MLDSA_CTRL_IRQ_EN
  logic            irq_en_q, irq_en_d, irq_q, irq_d;
`endif

  logic [31:0] ctrl_rd, status_rd, rd_val;
  logic        rd_hit, commit, wr_ctrl, wr_stat;
  logic [NUM_CFG-1:0] wr_cfg;
  logic        set_done, set_err, clr_done, clr_err;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[8 +: MODE_W] = mode_q;
`ifdef MLDSA_CTRL_IRQ_EN
    ctrl_rd[1] = irq_en_q;
`endif
    status_rd = {29'd0, start_err_q, done_st_q, busy_q};

    rd_val = '0;
    rd_hit = 1'b0;
    if (ARADDR[ADDR_W-1:2] == WA_W'(0)) begin
      rd_val = ctrl_rd;
      rd_hit = 1'b1;
    end else if (ARADDR[ADDR_W-1:2] == WA_W'(1)) begin
      rd_val = status_rd;
      rd_hit = 1'b1;
    end
    for (int unsigned i = 0; i < NUM_CFG; i++) begin
      if (ARADDR[ADDR_W-1:2] == WA_W'(4 + i)) begin
        rd_val = cfg_q[i];
        rd_hit = 1'b1;
      end
    end

    wr_ctrl = (awaddr_q == WA_W'(0));
    wr_stat = (awaddr_q == WA_W'(1));
    for (int unsigned i = 0; i < NUM_CFG; i++) wr_cfg[i] = (awaddr_q == WA_W'(4 + i));
  end

  always_comb begin
    aw_held_d = aw_held_q;  awaddr_d = awaddr_q;
    w_held_d  = w_held_q;   wdata_d  = wdata_q;   wstrb_d = wstrb_q;
    bvalid_d  = bvalid_q;   bresp_d  = bresp_q;
    rvalid_d  = rvalid_q;   rdata_d  = rdata_q;   rresp_d = rresp_q;
    mode_d    = mode_q;     cfg_d    = cfg_q;
    busy_d    = busy_q;     start_d  = 1'b0;
`ifdef MLDSA_CTRL_IRQ_EN
    irq_en_d  = irq_en_q;
`endif
    set_done = 1'b0; set_err = 1'b0; clr_done = 1'b0; clr_err = 1'b0;
    commit = aw_held_q & w_held_q & ~bvalid_q;

    if (AWVALID && !aw_held_q) begin
      aw_held_d = 1'b1;
      awaddr_d  = AWADDR[ADDR_W-1:2];
    end
    if (WVALID && !w_held_q) begin
      w_held_d = 1'b1;
      wdata_d  = WDATA;
      wstrb_d  = WSTRB;
    end
    if (bvalid_q && BREADY) bvalid_d = 1'b0;

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = (wr_ctrl || wr_stat || (|wr_cfg)) ? RESP_OKAY : RESP_SLVERR;
      if (wr_ctrl) begin
        // MODE is assumed to fit in byte lane 1 (MODE_W <= 8)
        if (wstrb_q[1]) mode_d = wdata_q[8 +: MODE_W];
`ifdef MLDSA_CTRL_IRQ_EN
        if (wstrb_q[0]) irq_en_d = wdata_q[1];
`endif
        if (wstrb_q[0] && wdata_q[0]) begin
          if (busy_q) set_err = 1'b1;
          else begin
            start_d = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end
      if (wr_stat && wstrb_q[0]) begin
        clr_done = wdata_q[1];
        clr_err  = wdata_q[2];
      end
      for (int unsigned i = 0; i < NUM_CFG; i++) begin
        if (wr_cfg[i]) cfg_d[i] = merge_bytes(cfg_q[i], wdata_q, wstrb_q);
      end
    end

    if (busy_q && done) begin
      busy_d   = 1'b0;
      set_done = 1'b1;
    end
    done_st_d   = set_done | (done_st_q & ~clr_done);
    start_err_d = set_err | (start_err_q & ~clr_err);

    if (ARVALID && !rvalid_q) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
      rresp_d  = rd_hit ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && RREADY) begin
      rvalid_d = 1'b0;
    end
`ifdef MLDSA_CTRL_IRQ_EN
    // next-state terms so irq drops the cycle after a W1C commit
    irq_d = irq_en_d & (done_st_d | start_err_d);
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_held_q <= 1'b0;  awaddr_q <= '0;
      w_held_q  <= 1'b0;  wdata_q  <= '0;  wstrb_q <= '0;
      bvalid_q  <= 1'b0;  bresp_q  <= '0;
      rvalid_q  <= 1'b0;  rdata_q  <= '0;  rresp_q <= '0;
      mode_q    <= '0;
      for (int unsigned i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
      busy_q    <= 1'b0;  start_q  <= 1'b0;
      done_st_q <= 1'b0;  start_err_q <= 1'b0;
`ifdef MLDSA_CTRL_IRQ_EN
      irq_en_q  <= 1'b0;  irq_q    <= 1'b0;
`endif
    end else begin
      aw_held_q <= aw_held_d;  awaddr_q <= awaddr_d;
      w_held_q  <= w_held_d;   wdata_q  <= wdata_d;  wstrb_q <= wstrb_d;
      bvalid_q  <= bvalid_d;   bresp_q  <= bresp_d;
      rvalid_q  <= rvalid_d;   rdata_q  <= rdata_d;  rresp_q <= rresp_d;
      mode_q    <= mode_d;
      cfg_q     <= cfg_d;
      busy_q    <= busy_d;     start_q  <= start_d;
      done_st_q <= done_st_d;  start_err_q <= start_err_d;
`ifdef MLDSA_CTRL_IRQ_EN
      irq_en_q  <= irq_en_d;   irq_q    <= irq_d;
`endif
    end
  end

  assign AWREADY     = ~aw_held_q;
  assign WREADY      = ~w_held_q;
  assign BVALID      = bvalid_q;
  assign BRESP       = bresp_q;
  assign ARREADY     = ~rvalid_q;
  assign RVALID      = rvalid_q;
  assign RDATA       = rdata_q;
  assign RRESP       = rresp_q;
  assign main_mode   = mode_q;
  assign start_pulse = start_q;
  assign busy        = busy_q;
`ifdef MLDSA_CTRL_IRQ_EN
  assign irq         = irq_q;
`endif

  always_comb begin
    for (int unsigned i = 0; i < NUM_CFG; i++) cfg_flat[32*i +: 32] = cfg_q[i];
  end
endmodule

// File: tb/tb_axi4_lite_ctrl_regs.sv
// Bench for axi4_lite_ctrl_regs: directed register-map scenarios plus random AXI traffic
// compared every cycle against a queue-based transaction model.
module tb_axi4_lite_ctrl_regs;
  localparam int ADDR_W  = 12;
  localparam int MODE_W  = 2;
  localparam int NUM_CFG = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [ADDR_W-1:0] AWADDR = '0, ARADDR = '0;
  logic AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic done = 1'b0;
  logic AWREADY, WREADY, BVALID, ARREADY, RVALID, start_pulse, busy;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA;
  logic [MODE_W-1:0] main_mode;
  logic [32*NUM_CFG-1:0] cfg_flat;
`ifdef MLDSA_CTRL_IRQ_EN
  logic irq;
`endif

  axi4_lite_ctrl_regs #(.ADDR_W(ADDR_W), .MODE_W(MODE_W), .NUM_CFG(NUM_CFG)) dut (
    .clk(clk), .resetn(resetn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .main_mode(main_mode), .cfg_flat(cfg_flat), .start_pulse(start_pulse),
`ifdef MLDSA_CTRL_IRQ_EN
    .irq(irq),
`endif
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_start = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [11:0] m_aw [$];
  logic [35:0] m_w [$];
  bit m_bv, m_rv, m_busy, m_dst, m_err, m_start;
  bit m_aw_acc, m_w_acc, m_ar_acc;
  logic [1:0]  m_br, m_rr, m_mode;
  logic [31:0] m_rd;
  logic [31:0] m_cfg [NUM_CFG];
`ifdef MLDSA_CTRL_IRQ_EN
  bit m_ien, m_irq;
`endif

  function automatic int cfg_idx(input logic [11:0] a);
    int unsigned w;
    w = {20'd0, a[11:2], 2'b00};
    if (w >= 32'h10 && w < 32'h10 + 4 * NUM_CFG) return int'((w - 32'h10) / 4);
    return -1;
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [127:0] exp_cfg();
    logic [127:0] r;
    for (int i = 0; i < NUM_CFG; i++) r[32*i +: 32] = m_cfg[i];
    return r;
  endfunction

  task automatic m_reset();
    m_aw.delete(); m_w.delete();
    m_bv = 0; m_rv = 0; m_busy = 0; m_dst = 0; m_err = 0; m_start = 0;
    m_aw_acc = 0; m_w_acc = 0; m_ar_acc = 0;
    m_br = 0; m_rr = 0; m_mode = 0; m_rd = 0;
    for (int i = 0; i < NUM_CFG; i++) m_cfg[i] = 0;
`ifdef MLDSA_CTRL_IRQ_EN
    m_ien = 0; m_irq = 0;
`endif
  endtask

  task automatic m_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r);
    int unsigned w;
    int ci;
    w = {20'd0, a[11:2], 2'b00};
    ci = cfg_idx(a);
    d = 0;
    r = 2'b00;
    if (w == 0) begin
      d = 32'(m_mode) << 8;
`ifdef MLDSA_CTRL_IRQ_EN
      if (m_ien) d = d | 32'h2;
`endif
    end else if (w == 4) d = {29'd0, m_err, m_dst, m_busy};
    else if (ci >= 0) d = m_cfg[ci];
    else r = 2'b10;
  endtask

  task automatic m_step();
    bit can_aw, can_w, busy0, commit, start, set_d, set_e, clr_d, clr_e;
    logic [11:0] a;
    logic [35:0] wd;
    logic [31:0] d;
    logic [3:0]  s;
    int unsigned w;
    int ci;
    can_aw = (m_aw.size() == 0);
    can_w  = (m_w.size() == 0);
    busy0  = m_busy;
    commit = !can_aw && !can_w && !m_bv;
    start = 0; set_d = 0; set_e = 0; clr_d = 0; clr_e = 0;
    m_ar_acc = ARVALID && !m_rv;
    if (m_ar_acc) begin
      m_read(ARADDR, m_rd, m_rr);
      m_rv = 1;
    end else if (m_rv && RREADY) m_rv = 0;
    if (m_bv && BREADY) m_bv = 0;
    if (commit) begin
      a = m_aw.pop_front();
      wd = m_w.pop_front();
      d = wd[31:0];
      s = wd[35:32];
      w = {20'd0, a[11:2], 2'b00};
      ci = cfg_idx(a);
      m_bv = 1;
      m_br = 2'b00;
      if (w == 0) begin
        if (s[1]) m_mode = d[9:8];
`ifdef MLDSA_CTRL_IRQ_EN
        if (s[0]) m_ien = d[1];
`endif
        if (s[0] && d[0]) begin
          if (busy0) set_e = 1;
          else start = 1;
        end
      end else if (w == 4) begin
        if (s[0]) begin
          clr_d = d[1];
          clr_e = d[2];
        end
      end else if (ci >= 0) m_cfg[ci] = bmerge(m_cfg[ci], d, s);
      else m_br = 2'b10;
    end
    if (busy0 && done) begin
      m_busy = 0;
      set_d = 1;
    end
    if (start) m_busy = 1;
    m_start = start;
    m_dst = set_d || (m_dst && !clr_d);
    m_err = set_e || (m_err && !clr_e);
    m_aw_acc = AWVALID && can_aw;
    if (m_aw_acc) m_aw.push_back(AWADDR);
    m_w_acc = WVALID && can_w;
    if (m_w_acc) m_w.push_back({WSTRB, WDATA});
`ifdef MLDSA_CTRL_IRQ_EN
    m_irq = m_ien && (m_dst || m_err);
`endif
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) m_reset();
      else m_step();
    end
  end

  // every-cycle comparison against the model
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("awready", AWREADY, m_aw.size() == 0);
      check("wready", WREADY, m_w.size() == 0);
      check("arready", ARREADY, !m_rv);
      check("bvalid", BVALID, m_bv);
      if (m_bv) check("bresp", BRESP, m_br);
      check("rvalid", RVALID, m_rv);
      if (m_rv) begin
        check("rdata", RDATA, m_rd);
        check("rresp", RRESP, m_rr);
      end
      check("main_mode", main_mode, m_mode);
      check("cfg_flat", cfg_flat, exp_cfg());
      check("start_pulse", start_pulse, m_start);
      check("busy", busy, m_busy);
`ifdef MLDSA_CTRL_IRQ_EN
      check("irq", irq, m_irq);
`endif
      if (start_pulse) n_start++;
    end
  end

  // ---------------- bus tasks ----------------
  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int lead, output logic [1:0] resp);
    bit aw_ok, w_ok, got;
    aw_ok = 0; w_ok = 0; got = 0; resp = 2'bxx;
    @(negedge clk);
    BREADY = 1; WDATA = d; WSTRB = s; WVALID = 1; AWADDR = a; AWVALID = (lead == 0);
    for (int k = 0; k < 40 && !(aw_ok && w_ok); k++) begin
      @(negedge clk);
      if (AWVALID && m_aw_acc) begin aw_ok = 1; AWVALID = 0; end
      if (WVALID && m_w_acc) begin w_ok = 1; WVALID = 0; end
      if (!aw_ok && !AWVALID) begin
        check("b_before_aw", BVALID, 1'b0);
        if (k + 1 >= lead) AWVALID = 1;
      end
    end
    for (int k = 0; k < 40 && !got; k++) begin
      if (BVALID) begin got = 1; resp = BRESP; end
      @(negedge clk);
    end
    if (!got) check("b_timeout", 1'b0, 1'b1);
    AWVALID = 0; WVALID = 0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit acc, got;
    acc = 0; got = 0; d = 'x; resp = 2'bxx;
    @(negedge clk);
    RREADY = 1; ARADDR = a; ARVALID = 1;
    for (int k = 0; k < 40 && !acc; k++) begin
      @(negedge clk);
      if (m_ar_acc) begin acc = 1; ARVALID = 0; end
    end
    for (int k = 0; k < 40 && !got; k++) begin
      if (RVALID) begin got = 1; d = RDATA; resp = RRESP; end
      @(negedge clk);
    end
    if (!got) check("r_timeout", 1'b0, 1'b1);
    ARVALID = 0;
  endtask

  function automatic logic [11:0] rand_addr();
    logic [11:0] a;
    case ($urandom_range(0, 9))
      0: a = 12'h000;
      1: a = 12'h004;
      2: a = 12'h010;
      3: a = 12'h014;
      4: a = 12'h018;
      5: a = 12'h01C;
      6: a = 12'h040;
      7: a = 12'h044;
      8: a = 12'h008;
      default: a = 12'($urandom);
    endcase
    a[1:0] = 2'($urandom);
    return a;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  resp;
    logic [31:0] d;
    int          n_wait;
    repeat (3) @(negedge clk);
    resetn = 1;
    @(negedge clk);
    check("rst_awready", AWREADY, 1'b1);
    check("rst_wready", WREADY, 1'b1);
    check("rst_arready", ARREADY, 1'b1);
    check("rst_bvalid", BVALID, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cfg", cfg_flat, 128'h0);

    wr(12'h000, 32'h0000_0201, 4'b0011, 0, resp);
    check("start_bresp", resp, 2'b00);
    check("start_mode", main_mode, 2'd2);
    check("start_busy", busy, 1'b1);
    check("start_count", n_start, 1);
    rd(12'h004, d, resp);
    check("status_busy", d, 32'h1);

    wr(12'h018, 32'hA5A5_A5A5, 4'b0101, 2, resp);
    check("cfg2_bresp", resp, 2'b00);
    rd(12'h018, d, resp);
    check("cfg2_strb", d, 32'h00A5_00A5);

    wr(12'h000, 32'h0000_0201, 4'b0011, 0, resp);
    check("busy_start_bresp", resp, 2'b00);
    check("no_second_start", n_start, 1);
    rd(12'h004, d, resp);
    check("status_err", d, 32'h5);
    @(negedge clk); done = 1;
    @(negedge clk); done = 0;
    check("done_busy", busy, 1'b0);
    rd(12'h004, d, resp);
    check("status_sticky", d, 32'h6);
    wr(12'h004, 32'h6, 4'b0001, 0, resp);
    rd(12'h004, d, resp);
    check("status_w1c", d, 32'h0);

    rd(12'h040, d, resp);
    check("unmapped_rresp", resp, 2'b10);
    check("unmapped_rdata", d, 32'h0);
    wr(12'h044, 32'hFFFF_FFFF, 4'hF, 0, resp);
    check("unmapped_bresp", resp, 2'b10);
    check("unmapped_nochg", cfg_flat, 128'h0000_0000_00A5_00A5_0000_0000_0000_0000);
    check("unmapped_mode", main_mode, 2'd2);

    // B back-pressure with a second write queued behind it
    @(negedge clk);
    BREADY = 0; AWADDR = 12'h010; WDATA = 32'h1111_1111; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    @(negedge clk);
    AWVALID = 0; WVALID = 0;
    n_wait = 0;
    while (!BVALID && n_wait < 10) begin @(negedge clk); n_wait++; end
    check("bp_first_b", BVALID, 1'b1);
    AWADDR = 12'h014; WDATA = 32'h2222_2222; AWVALID = 1; WVALID = 1;
    @(negedge clk);
    AWVALID = 0; WVALID = 0;
    repeat (5) begin
      @(negedge clk);
      check("bp_bvalid", BVALID, 1'b1);
      check("bp_bresp", BRESP, 2'b00);
      check("bp_cfg1_hold", cfg_flat[63:32], 32'h0);
    end
    check("bp_cfg0", cfg_flat[31:0], 32'h1111_1111);
    BREADY = 1;
    @(negedge clk);
    check("bp_b_done", BVALID, 1'b0);
    check("bp_cfg1_wait", cfg_flat[63:32], 32'h0);
    @(negedge clk);
    check("bp_second_b", BVALID, 1'b1);
    check("bp_cfg1", cfg_flat[63:32], 32'h2222_2222);
    @(negedge clk);

    // reset while B and R are pending and busy is high
    wr(12'h000, 32'h0000_0101, 4'b0011, 0, resp);
    check("pre_rst_busy", busy, 1'b1);
    @(negedge clk);
    BREADY = 0; RREADY = 0;
    AWADDR = 12'h01C; WDATA = 32'h3333_3333; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    ARADDR = 12'h010; ARVALID = 1;
    @(negedge clk);
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    n_wait = 0;
    while (!BVALID && n_wait < 10) begin @(negedge clk); n_wait++; end
    check("pre_rst_bvalid", BVALID, 1'b1);
    #2 resetn = 0;
    #1;
    check("mid_rst_bvalid", BVALID, 1'b0);
    check("mid_rst_rvalid", RVALID, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_start", start_pulse, 1'b0);
    check("mid_rst_mode", main_mode, 2'd0);
    check("mid_rst_cfg", cfg_flat, 128'h0);
    check("mid_rst_awready", AWREADY, 1'b1);
    @(negedge clk);
    resetn = 1; BREADY = 1; RREADY = 1;
    @(negedge clk);

`ifdef MLDSA_CTRL_IRQ_EN
    wr(12'h000, 32'h0000_0003, 4'b0001, 0, resp);
    check("irq_idle", irq, 1'b0);
    @(negedge clk); done = 1;
    @(negedge clk); done = 0;
    check("irq_set", irq, 1'b1);
    wr(12'h004, 32'h2, 4'b0001, 0, resp);
    check("irq_clear", irq, 1'b0);
`endif

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (!AWVALID || m_aw_acc) begin
        AWVALID = ($urandom_range(0, 2) == 0);
        AWADDR = rand_addr();
      end
      if (!WVALID || m_w_acc) begin
        WVALID = ($urandom_range(0, 2) == 0);
        WDATA = $urandom;
        WSTRB = 4'($urandom);
      end
      if (!ARVALID || m_ar_acc) begin
        ARVALID = ($urandom_range(0, 2) == 0);
        ARADDR = rand_addr();
      end
      BREADY = ($urandom_range(0, 3) != 0);
      RREADY = ($urandom_range(0, 3) != 0);
      done = ($urandom_range(0, 11) == 0);
    end
    @(negedge clk);
    AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 1; RREADY = 1; done = 0;
    repeat (20) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi4_lite_ctrl_regs.md
Name: axi4_lite_ctrl_regs

Overview:
- Parametrised AXI4-Lite control/status register slave for the MLDSA core. Successor to the single-mode control slave.
- Adds a decoded register map, N config registers, WSTRB byte enables and independent AW/W acceptance.
- Adds a registered read channel, sticky done/error status and SLVERR on unmapped addresses.
- Sits between the AXI interconnect and the MLDSA top; drives mode, config words and a one-cycle start pulse; samples done.

Parameters:
- ADDR_W, 12, AXI address width used for decode; upper address bits are ignored.
- MODE_W, 2, width of main_mode field (CTRL[8+MODE_W-1:8]).
- NUM_CFG, 4, number of 32-bit config registers (1..16).

Ports:
- clk  in  1  clock, all logic rising-edge.
- resetn  in  1  asynchronous active-low reset.
- AWADDR  in  ADDR_W  write address. AWVALID in 1. AWREADY out 1.
- WDATA  in  32  write data. WSTRB in 4. WVALID in 1. WREADY out 1.
- BRESP  out  2  write response. BVALID out 1. BREADY in 1.
- ARADDR  in  ADDR_W  read address. ARVALID in 1. ARREADY out 1.
- RDATA  out  32  read data. RRESP out 2. RVALID out 1. RREADY in 1.
- main_mode  out  MODE_W  selected MLDSA operation.
- cfg_flat  out  32*NUM_CFG  config words; word i at bits [32i+31:32i].
- start_pulse  out  1  one-cycle start strobe to MLDSA.
- done  in  1  MLDSA completion, single-cycle pulse or level.
- busy  out  1  high from start_pulse until done is sampled high.

Behaviour:
- Reset values: all outputs and registers 0. AWREADY=WREADY=ARREADY=1 (no capture pending).
- Register map (word offsets, ADDR[1:0] ignored):
  - 0x00 CTRL: bit0 START, write-1 self-clearing, reads 0. Bits[8+MODE_W-1:8] MODE, RW.
  - 0x04 STATUS: bit0 busy (RO), bit1 done_sticky (W1C), bit2 start_err (W1C).
  - 0x10+4i CFG[i]: RW, for i < NUM_CFG.
  - Any other offset: write discarded, BRESP=2'b10; read RDATA=0, RRESP=2'b10. Mapped accesses return 2'b00.
- Write path:
  - AW and W are captured independently into holding registers. AWREADY = !aw_held; WREADY = !w_held.
  - Commit happens in the first cycle where aw_held & w_held & !BVALID. Only lanes with WSTRB[b]=1 update byte b.
  - BVALID rises the cycle after commit and holds with BRESP stable until BREADY. Both holds clear at commit, so the next AW/W can be captured while B is pending; the next commit waits for B to complete.
  - Same-cycle AWVALID&WVALID with both holds empty: captured together; BVALID two cycles later.
- Start:
  - A commit to CTRL with WSTRB[0]=1, WDATA[0]=1 and busy=0: start_pulse high the cycle after commit; busy set in the same cycle.
  - MODE bits written in the same commit are visible on main_mode no later than start_pulse.
  - If busy=1, START is ignored, start_err is set and BRESP is still OKAY.
  - MODE and CFG writes while busy=1 are accepted; MLDSA samples them only at start.
- Done: done=1 while busy: busy clears next cycle and done_sticky is set. done while !busy is ignored.
- Status conflict: a W1C clearing a sticky bit in the same cycle it is set leaves the bit set (set wins).
- Read path:
  - ARREADY = !RVALID. On ARVALID&ARREADY, RDATA/RRESP are registered and RVALID rises the next cycle, holding until RREADY.
  - A read committing in the same cycle as a write to the same register returns the pre-write value.
- Reset mid-transaction: all holds, BVALID, RVALID, busy and sticky bits clear immediately; no start_pulse is generated.

Optional Feature:
- Macro MLDSA_CTRL_IRQ_EN.
- Defined:
  - Adds output irq (1 bit, registered) and CTRL bit1 IRQ_ENABLE (RW, reset 0).
  - irq = IRQ_ENABLE & (done_sticky | start_err); it deasserts the cycle after the W1C clear commits.
- Undefined: no irq port; CTRL bit1 reads 0 and writes are ignored.

Test Plan:
- Write CTRL=0x0000_0201 (MODE=2, START), BREADY=1 -> BRESP=00; main_mode=2; start_pulse one cycle; busy=1; STATUS read=0x1.
- Drive W two cycles before AW to CFG[2] (0x18), data 0xA5A5_A5A5, WSTRB=4'b0101 -> CFG[2]=0x00A5_00A5; BVALID only after AW captured.
- START while busy -> start_err=1; no second start_pulse. Pulse done -> busy=0; STATUS=0x6. Write STATUS=0x6 -> STATUS=0x0.
- Read 0x40 and write 0x44 -> RRESP=10, RDATA=0; BRESP=10; no register changes.
- Hold BREADY=0 for 5 cycles with a second AW/W queued -> BVALID/BRESP stable; second commit only after first B handshake.
- Assert resetn=0 while BVALID=1 and busy=1 -> all outputs 0 the same cycle. With MLDSA_CTRL_IRQ_EN: IRQ_ENABLE=1, done pulse -> irq=1 until W1C.
